// File: rtl/in_service_8259a.sv
// 8259A in-service register with rotating-priority resolution of the highest
// level in service; the priority result is registered one clock behind the ISR.
module in_service_8259a (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] priority_rotate,
  input  logic [7:0] interrupt_special_mask,
  input  logic [7:0] interrupt,
  input  logic       latch_in_service,
  input  logic [7:0] end_of_interrupt,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service
);

  logic [7:0]  w_isr_next;
  logic [7:0]  w_masked;
  logic [2:0]  w_amt;
  logic [15:0] w_dbl_r;
  logic [7:0]  w_rot;
  logic [7:0]  w_iso;
  logic [15:0] w_dbl_l;
  logic [7:0]  w_level;

  // Set has priority over clear because the OR is applied after the EOI mask.
  assign w_isr_next = (in_service_register & ~end_of_interrupt)
                    | (latch_in_service ? interrupt : 8'h00);

  assign w_masked = in_service_register & ~interrupt_special_mask;
  // 3-bit add wraps 7 to 0, so priority_rotate=7 gives no rotation.
  assign w_amt    = priority_rotate + 3'd1;
  assign w_dbl_r  = {w_masked, w_masked} >> w_amt;
  assign w_rot    = w_dbl_r[7:0];
  assign w_iso    = w_rot & (~w_rot + 8'd1);
  assign w_dbl_l  = {w_iso, w_iso} << w_amt;
  assign w_level  = w_dbl_l[15:8];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_service_register      <= 8'h00;
      highest_level_in_service <= 8'h00;
    end else begin
      in_service_register      <= w_isr_next;
      highest_level_in_service <= w_level;
    end
  end

endmodule

// File: tb/tb_in_service_8259a.sv
// Self-checking bench for in_service_8259a: directed scenarios plus random
// traffic against a priority-scan reference model.
module tb_in_service_8259a;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] priority_rotate;
  logic [7:0] interrupt_special_mask;
  logic [7:0] interrupt;
  logic       latch_in_service;
  logic [7:0] end_of_interrupt;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_isr;
  logic [7:0] m_hl;

  in_service_8259a dut (
    .clock                    (clock),
    .reset                    (reset),
    .priority_rotate          (priority_rotate),
    .interrupt_special_mask   (interrupt_special_mask),
    .interrupt                (interrupt),
    .latch_in_service         (latch_in_service),
    .end_of_interrupt         (end_of_interrupt),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service)
  );

  always #5 clock = ~clock;

  // Walk levels from highest priority (rot+1) downwards; first unmasked hit wins.
  function automatic logic [7:0] ref_hl(input logic [7:0] isr, input logic [2:0] rot,
                                        input logic [7:0] mask);
    for (int k = 1; k <= 8; k++) begin
      int lvl;
      lvl = (int'(rot) + k) % 8;
      if (isr[lvl] && !mask[lvl]) return 8'h01 << lvl;
    end
    return 8'h00;
  endfunction

  // One rising edge: model computes its next state from the inputs present at the edge.
  task automatic tick();
    logic [7:0] n_isr, n_hl;
    n_hl  = ref_hl(m_isr, priority_rotate, interrupt_special_mask);
    n_isr = (m_isr & ~end_of_interrupt) | (latch_in_service ? interrupt : 8'h00);
    @(posedge clock);
    #1;
    if (reset) begin
      m_isr = 8'h00;
      m_hl  = 8'h00;
    end else begin
      m_isr = n_isr;
      m_hl  = n_hl;
    end
  endtask

  task automatic idle();
    latch_in_service = 1'b0;
    interrupt        = 8'h00;
    end_of_interrupt = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    priority_rotate = 3'd7;
    interrupt_special_mask = 8'h00;
    idle();
    #2;
    total++;
    if (in_service_register !== 8'h00) begin
      bad++; $display("FAIL reset_isr got=%h exp=00", in_service_register);
    end
    total++;
    if (highest_level_in_service !== 8'h00) begin
      bad++; $display("FAIL reset_hl got=%h exp=00", highest_level_in_service);
    end
    tick(); tick();
    reset = 1'b0;
    m_isr = 8'h00; m_hl = 8'h00;
    tick();
    total++;
    if (in_service_register !== 8'h00 || highest_level_in_service !== 8'h00) begin
      bad++; $display("FAIL post_reset got=%h/%h exp=00/00", in_service_register, highest_level_in_service);
    end
  endtask

  task automatic test_seq_latch();
    logic [7:0] lv;
    priority_rotate = 3'd7;
    interrupt_special_mask = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      lv = 8'h01 << i;
      latch_in_service = 1'b1; interrupt = lv;
      tick();
      idle();
      total++;
      if (in_service_register !== m_isr || highest_level_in_service !== m_hl) begin
        bad++; $display("FAIL seq_latch[%0d] got=%h/%h exp=%h/%h", i,
                        in_service_register, highest_level_in_service, m_isr, m_hl);
      end
    end
    tick();
    total++;
    if (in_service_register !== 8'hFF || highest_level_in_service !== 8'h01) begin
      bad++; $display("FAIL seq_latch_final got=%h/%h exp=ff/01", in_service_register, highest_level_in_service);
    end
  endtask

  task automatic test_eoi_scan();
    priority_rotate = 3'd7;
    for (int i = 0; i < 8; i++) begin
      end_of_interrupt = 8'h01 << i;
      tick();
      idle();
      total++;
      if (in_service_register !== m_isr || highest_level_in_service !== m_hl) begin
        bad++; $display("FAIL eoi_scan[%0d] got=%h/%h exp=%h/%h", i,
                        in_service_register, highest_level_in_service, m_isr, m_hl);
      end
    end
    tick();
    total++;
    if (in_service_register !== 8'h00 || highest_level_in_service !== 8'h00) begin
      bad++; $display("FAIL eoi_scan_final got=%h/%h exp=00/00", in_service_register, highest_level_in_service);
    end
  endtask

  task automatic test_rotation();
    logic [2:0] rots [5];
    logic [7:0] isrs [5];
    logic [7:0] exps [5];
    rots = '{3'd3, 3'd0, 3'd6, 3'd0, 3'd3};
    isrs = '{8'hFF, 8'hFF, 8'hFF, 8'h09, 8'h09};
    exps = '{8'h10, 8'h02, 8'h80, 8'h08, 8'h01};
    interrupt_special_mask = 8'h00;
    for (int i = 0; i < 5; i++) begin
      end_of_interrupt = 8'hFF; latch_in_service = 1'b1; interrupt = isrs[i];
      tick();
      idle();
      priority_rotate = rots[i];
      tick();
      total++;
      if (highest_level_in_service !== exps[i] || in_service_register !== isrs[i]) begin
        bad++; $display("FAIL rotation[%0d] got=%h/%h exp=%h/%h", i,
                        in_service_register, highest_level_in_service, isrs[i], exps[i]);
      end
    end
    // Every rotation value against the model, with wrap-around.
    end_of_interrupt = 8'hFF; latch_in_service = 1'b1; interrupt = 8'h81;
    tick(); idle();
    for (int r = 0; r < 8; r++) begin
      priority_rotate = 3'(r);
      tick();
      total++;
      if (highest_level_in_service !== m_hl) begin
        bad++; $display("FAIL rot_all[%0d] got=%h exp=%h", r, highest_level_in_service, m_hl);
      end
    end
  endtask

  task automatic test_special_mask();
    priority_rotate = 3'd7;
    interrupt_special_mask = 8'h00;
    end_of_interrupt = 8'hFF; latch_in_service = 1'b1; interrupt = 8'h05;
    tick(); idle();
    interrupt_special_mask = 8'h01;
    tick();
    total++;
    if (highest_level_in_service !== 8'h04 || in_service_register !== 8'h05) begin
      bad++; $display("FAIL smm_01 got=%h/%h exp=05/04", in_service_register, highest_level_in_service);
    end
    interrupt_special_mask = 8'h05;
    tick();
    total++;
    if (highest_level_in_service !== 8'h00 || in_service_register !== 8'h05) begin
      bad++; $display("FAIL smm_05 got=%h/%h exp=05/00", in_service_register, highest_level_in_service);
    end
    interrupt_special_mask = 8'h00;
    tick();
    total++;
    if (highest_level_in_service !== 8'h01 || in_service_register !== 8'h05) begin
      bad++; $display("FAIL smm_00 got=%h/%h exp=05/01", in_service_register, highest_level_in_service);
    end
  endtask

  task automatic test_set_clear();
    end_of_interrupt = 8'hFF; latch_in_service = 1'b1; interrupt = 8'h10;
    tick();
    end_of_interrupt = 8'h11; latch_in_service = 1'b1; interrupt = 8'h10;
    tick(); idle();
    total++;
    if (in_service_register !== 8'h10) begin
      bad++; $display("FAIL set_wins got=%h exp=10", in_service_register);
    end
    end_of_interrupt = 8'hFF; latch_in_service = 1'b1; interrupt = 8'h11;
    tick(); idle();
    end_of_interrupt = 8'h01;
    tick(); idle();
    total++;
    if (in_service_register !== 8'h10) begin
      bad++; $display("FAIL eoi_only got=%h exp=10", in_service_register);
    end
    interrupt = 8'h0F; latch_in_service = 1'b0;
    tick(); idle();
    total++;
    if (in_service_register !== 8'h10) begin
      bad++; $display("FAIL latch_low got=%h exp=10", in_service_register);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      priority_rotate        = 3'($urandom_range(0, 7));
      interrupt_special_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      latch_in_service       = 1'($urandom);
      interrupt              = 8'h01 << $urandom_range(0, 7);
      end_of_interrupt       = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      tick();
      total++;
      if (in_service_register !== m_isr || highest_level_in_service !== m_hl) begin
        bad++; $display("FAIL random[%0d] got=%h/%h exp=%h/%h", i,
                        in_service_register, highest_level_in_service, m_isr, m_hl);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    priority_rotate = 3'd7; interrupt_special_mask = 8'h00;
    end_of_interrupt = 8'hFF; latch_in_service = 1'b1; interrupt = 8'hA5;
    tick(); idle();
    tick();
    total++;
    if (in_service_register !== 8'hA5 || highest_level_in_service !== 8'h01) begin
      bad++; $display("FAIL pre_reset got=%h/%h exp=a5/01", in_service_register, highest_level_in_service);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (in_service_register !== 8'h00 || highest_level_in_service !== 8'h00) begin
      bad++; $display("FAIL async_reset got=%h/%h exp=00/00", in_service_register, highest_level_in_service);
    end
    m_isr = 8'h00; m_hl = 8'h00;
    latch_in_service = 1'b1; interrupt = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (in_service_register !== 8'h00 || highest_level_in_service !== 8'h00) begin
        bad++; $display("FAIL reset_hold[%0d] got=%h/%h exp=00/00", i,
                        in_service_register, highest_level_in_service);
      end
    end
    #2 reset = 1'b0;
    interrupt = 8'h40;
    tick(); idle();
    total++;
    if (in_service_register !== 8'h40) begin
      bad++; $display("FAIL reset_release got=%h exp=40", in_service_register);
    end
  endtask

  initial begin
    m_isr = 8'h00; m_hl = 8'h00;
    test_reset();
    test_seq_latch();
    test_eoi_scan();
    test_rotation();
    test_special_mask();
    test_set_clear();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
